// File: rtl/prim_ram_2p_fifo_pkg.sv
// Shared types for the 2-port-RAM FIFO controller: output buffer size and
// wrap-aware pointer (index + phase) handling for arbitrary depths.
package prim_ram_2p_fifo_pkg;

    localparam int OutBufDepth = 2;
    localparam int MaxAw       = 16;

    typedef struct packed {
        logic             phase;
        logic [MaxAw-1:0] idx;
    } ptr_t;

    // Depth need not be a power of two, so the wrap point is explicit.
    function automatic ptr_t ptr_inc(input ptr_t p, input int depth);
        ptr_t r;
        if (p.idx == MaxAw'(depth - 1)) begin
            r.idx   = '0;
            r.phase = ~p.phase;
        end else begin
            r.idx   = p.idx + MaxAw'(1);
            r.phase = p.phase;
        end
        return r;
    endfunction

endpackage

// File: rtl/prim_ram_2p_fifo_outbuf.sv
// Two-entry output buffer; entry 0 is the head and drives data_o directly
// from a register.
module prim_ram_2p_fifo_outbuf
    import prim_ram_2p_fifo_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       cnt_o
);

    logic [Width-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop_eff, push_eff;

    assign pop_eff  = pop_i && (cnt_q != 2'd0);
    assign push_eff = push_i && ((cnt_q != 2'(OutBufDepth)) || pop_eff);

    always_comb begin
        d0_d  = d0_q;
        d1_d  = d1_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_eff, pop_eff})
                2'b10: begin
                    if (cnt_q == 2'd0) d0_d = data_i;
                    else               d1_d = data_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd2) d0_d = d1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind whatever stays.
                    if (cnt_q == 2'd1) begin
                        d0_d = data_i;
                    end else begin
                        d0_d = d1_q;
                        d1_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d0_q  <= '0;
            d1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = d0_q;
    assign valid_o = (cnt_q != 2'd0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/prim_ram_2p_fifo_ctrl.sv
// FIFO controller driving an external dual-port SRAM (A write, B read).
// Define PRIM_RAM_2P_FIFO_BYPASS_EN to let pushes skip the RAM when it is empty.
module prim_ram_2p_fifo_ctrl
    import prim_ram_2p_fifo_pkg::*;
#(
    parameter  int Width  = 32,
    parameter  int Depth  = 128,
    localparam int Aw     = $clog2(Depth),
    localparam int DepthW = $clog2(Depth + 3)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o,
    output logic              ram_a_req_o,
    output logic              ram_a_write_o,
    output logic [Aw-1:0]     ram_a_addr_o,
    output logic [Width-1:0]  ram_a_wdata_o,
    output logic [Width-1:0]  ram_a_wmask_o,
    output logic              ram_b_req_o,
    output logic              ram_b_write_o,
    output logic [Aw-1:0]     ram_b_addr_o,
    input  logic [Width-1:0]  ram_b_rdata_i
);

    localparam int CntW = $clog2(Depth + 1);

    ptr_t             wptr_q, wptr_d, rptr_q, rptr_d;
    logic             inflight_q, inflight_d;
    logic [MaxAw:0]   ptr_diff;
    logic [CntW-1:0]  ram_cnt;
    logic [1:0]       buf_cnt;
    logic [2:0]       occ;
    logic             push, pop, issue, bypass, ram_wr, buf_push;
    logic [Width-1:0] buf_data;

    // Occupancy from pointers only, so a same-cycle write is never readable yet.
    always_comb begin
        if (wptr_q.phase == rptr_q.phase) begin
            ptr_diff = {1'b0, wptr_q.idx} - {1'b0, rptr_q.idx};
        end else begin
            ptr_diff = {1'b0, wptr_q.idx} + (MaxAw + 1)'(Depth) - {1'b0, rptr_q.idx};
        end
    end
    assign ram_cnt = ptr_diff[CntW-1:0];

    assign wready_o = (ram_cnt != CntW'(Depth));
    assign push     = wvalid_i && wready_o && !clr_i;
    assign pop      = rvalid_o && rready_i && !clr_i;

`ifdef PRIM_RAM_2P_FIFO_BYPASS_EN
    assign bypass = push && (ram_cnt == '0) && !inflight_q && (buf_cnt != 2'(OutBufDepth));
`else
    assign bypass = 1'b0;
`endif

    assign ram_wr = push && !bypass;
    assign occ    = {1'b0, buf_cnt} + {2'b00, inflight_q};
    assign issue  = !clr_i && (ram_cnt != '0) && ((occ < 3'd2) || pop);

    always_comb begin
        wptr_d     = ram_wr ? ptr_inc(wptr_q, Depth) : wptr_q;
        rptr_d     = issue  ? ptr_inc(rptr_q, Depth) : rptr_q;
        inflight_d = issue;
        if (clr_i) begin
            wptr_d     = '0;
            rptr_d     = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
        end
    end

    // Bypass and RAM return are mutually exclusive (bypass needs inflight_q == 0).
    assign buf_push = !clr_i && (inflight_q || bypass);
    assign buf_data = bypass ? wdata_i : ram_b_rdata_i;

    prim_ram_2p_fifo_outbuf #(
        .Width (Width)
    ) u_outbuf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .push_i  (buf_push),
        .data_i  (buf_data),
        .pop_i   (pop),
        .data_o  (rdata_o),
        .valid_o (rvalid_o),
        .cnt_o   (buf_cnt)
    );

    assign depth_o = DepthW'(ram_cnt) + DepthW'(buf_cnt) + DepthW'(inflight_q);

    assign ram_a_req_o   = ram_wr;
    assign ram_a_write_o = 1'b1;
    assign ram_a_addr_o  = wptr_q.idx[Aw-1:0];
    assign ram_a_wdata_o = wdata_i;
    assign ram_a_wmask_o = '1;
    assign ram_b_req_o   = issue;
    assign ram_b_write_o = 1'b0;
    assign ram_b_addr_o  = rptr_q.idx[Aw-1:0];

endmodule

// File: tb/tb_prim_ram_2p_fifo_ctrl.sv
// Directed and randomised checks of prim_ram_2p_fifo_ctrl (Depth=5) with a
// behavioural dual-port RAM attached to its RAM ports.
module tb_prim_ram_2p_fifo_ctrl;

    localparam int W  = 32;
    localparam int D  = 5;
    localparam int AW = $clog2(D);
    localparam int DW = $clog2(D + 3);
`ifdef PRIM_RAM_2P_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [W-1:0]  wdata = '0;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [W-1:0]  rdata;
    logic [DW-1:0] depth;
    logic          a_req, a_write, b_req, b_write;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, a_wmask, b_rdata;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    prim_ram_2p_fifo_ctrl #(.Width(W), .Depth(D)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clr_i         (clr),
        .wvalid_i      (wvalid),
        .wready_o      (wready),
        .wdata_i       (wdata),
        .rvalid_o      (rvalid),
        .rready_i      (rready),
        .rdata_o       (rdata),
        .depth_o       (depth),
        .ram_a_req_o   (a_req),
        .ram_a_write_o (a_write),
        .ram_a_addr_o  (a_addr),
        .ram_a_wdata_o (a_wdata),
        .ram_a_wmask_o (a_wmask),
        .ram_b_req_o   (b_req),
        .ram_b_write_o (b_write),
        .ram_b_addr_o  (b_addr),
        .ram_b_rdata_i (b_rdata)
    );

    logic [W-1:0] mem [8];
    always @(posedge clk) begin
        if (a_req) mem[a_addr] <= a_wdata;
        if (b_req) b_rdata <= mem[b_addr];
    end

    // Tasks start and end 1 time unit after a rising edge; outputs are sampled at +2.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; wvalid = 1'b0; rready = 1'b0;
        #2;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        nvec++; if (rvalid !== 1'b0)   begin nerr++; $display("FAIL reset_rvalid got %0h want 0", rvalid); end
        nvec++; if (rdata !== '0)      begin nerr++; $display("FAIL reset_rdata got %0h want 0", rdata); end
        nvec++; if (depth !== '0)      begin nerr++; $display("FAIL reset_depth got %0d want 0", depth); end
        nvec++; if (wready !== 1'b1)   begin nerr++; $display("FAIL reset_wready got %0h want 1", wready); end
        nvec++; if (a_req !== 1'b0)    begin nerr++; $display("FAIL reset_a_req got %0h want 0", a_req); end
        nvec++; if (b_req !== 1'b0)    begin nerr++; $display("FAIL reset_b_req got %0h want 0", b_req); end
        nvec++; if (a_write !== 1'b1 || b_write !== 1'b0 || a_wmask !== 32'hFFFF_FFFF)
            begin nerr++; $display("FAIL ram_constants got %0h/%0h/%0h want 1/0/ffffffff", a_write, b_write, a_wmask); end
        next_cycle();
        $display("test_reset done");
    endtask

    task automatic test_single();
        int first = 0;
        logic [W-1:0] got = '0;
        do_reset();
        wdata = 32'hA5A5_0001; wvalid = 1'b1; rready = 1'b1;
        #1;
        nvec++; if (a_wdata !== 32'hA5A5_0001) begin nerr++; $display("FAIL single_a_wdata got %0h want a5a50001", a_wdata); end
        nvec++; if (a_req !== (LAT == 3)) begin nerr++; $display("FAIL single_a_req got %0h want %0h", a_req, LAT == 3); end
        next_cycle();
        wvalid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (rvalid === 1'b1 && first == 0) begin first = k; got = rdata; end
            next_cycle();
        end
        #1;
        nvec++; if (first != LAT) begin nerr++; $display("FAIL single_latency got %0d want %0d", first, LAT); end
        nvec++; if (got !== 32'hA5A5_0001) begin nerr++; $display("FAIL single_rdata got %0h want a5a50001", got); end
        nvec++; if (depth !== '0) begin nerr++; $display("FAIL single_depth_end got %0d want 0", depth); end
        rready = 1'b0;
        next_cycle();
        $display("test_single done latency=%0d", first);
    endtask

    task automatic test_full();
        int acc = 0;
        int n = 0;
        logic ok = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wvalid = 1'b1; wdata = 32'h100 + acc;
            #1;
            if (wready) acc++;
            next_cycle();
        end
        wvalid = 1'b0;
        #1;
        nvec++; if (acc != 7)        begin nerr++; $display("FAIL full_accepted got %0d want 7", acc); end
        nvec++; if (wready !== 1'b0) begin nerr++; $display("FAIL full_wready got %0h want 0", wready); end
        nvec++; if (depth !== 3'd7)  begin nerr++; $display("FAIL full_depth got %0d want 7", depth); end
        nvec++; if (rdata !== 32'h100) begin nerr++; $display("FAIL full_head got %0h want 100", rdata); end
        rready = 1'b1;
        next_cycle();
        rready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (wready === 1'b1) ok = 1'b1;
            next_cycle();
        end
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL full_wready_recover got %0h want 1", ok); end
        rready = 1'b1;
        for (int k = 0; k < 40 && n < 6; k++) begin
            #1;
            if (rvalid === 1'b1) begin
                nvec++;
                if (rdata !== 32'h101 + n) begin nerr++; $display("FAIL full_drain got %0h want %0h", rdata, 32'h101 + n); end
                n++;
            end
            next_cycle();
        end
        nvec++; if (n != 6) begin nerr++; $display("FAIL full_drain_count got %0d want 6", n); end
        rready = 1'b0;
        $display("test_full done accepted=%0d", acc);
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        bit started = 0;
        do_reset();
        rready = 1'b1;
        for (int k = 0; k < 1200 && recv < 1000; k++) begin
            wvalid = (sent < 1000); wdata = sent;
            #1;
            if (wvalid && wready) sent++;
            if (started || rvalid) begin
                started = 1;
                nvec++;
                if (rvalid !== 1'b1) begin nerr++; $display("FAIL stream_gap got rvalid=%0h want 1 at item %0d", rvalid, recv); end
                else if (rdata !== recv) begin nerr++; $display("FAIL stream_data got %0d want %0d", rdata, recv); end
                if (rvalid === 1'b1) recv++;
            end
            next_cycle();
        end
        wvalid = 1'b0; rready = 1'b0;
        nvec++; if (recv != 1000) begin nerr++; $display("FAIL stream_count got %0d want 1000", recv); end
        $display("test_back_to_back done received=%0d", recv);
    endtask

    task automatic test_addr_wrap();
        logic [W-1:0] q[$];
        int ea = 0;
        int eb = 0;
        logic [W-1:0] exp_d;
        do_reset();
        for (int round = 0; round < 4; round++) begin
            for (int c = 0; c < 12; c++) begin
                wvalid = (round % 2 == 0); rready = (round % 2 == 1); wdata = $urandom;
                #1;
                if (a_req === 1'b1) begin
                    nvec++; if (a_addr !== AW'(ea)) begin nerr++; $display("FAIL wrap_a_addr got %0d want %0d", a_addr, ea); end
                    ea = (ea + 1) % D;
                end
                if (b_req === 1'b1) begin
                    nvec++; if (b_addr !== AW'(eb)) begin nerr++; $display("FAIL wrap_b_addr got %0d want %0d", b_addr, eb); end
                    eb = (eb + 1) % D;
                end
                if (wvalid && wready) q.push_back(wdata);
                if (rvalid && rready) begin
                    exp_d = (q.size() > 0) ? q.pop_front() : 'x;
                    nvec++; if (rdata !== exp_d) begin nerr++; $display("FAIL wrap_data got %0h want %0h", rdata, exp_d); end
                end
                next_cycle();
            end
        end
        wvalid = 1'b0; rready = 1'b0;
        nvec++; if (q.size() != 0) begin nerr++; $display("FAIL wrap_leftover got %0d want 0", q.size()); end
        $display("test_addr_wrap done writes_mod=%0d reads_mod=%0d", ea, eb);
    endtask

    task automatic test_clear();
        int n = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wvalid = 1'b1; wdata = 32'hD0 + i;
            next_cycle();
        end
        wvalid = 1'b0;
        repeat (3) next_cycle();
        rready = 1'b1;
        #1;
        nvec++; if (b_req !== 1'b1) begin nerr++; $display("FAIL clr_issue got %0h want 1", b_req); end
        nvec++; if (rdata !== 32'hD0) begin nerr++; $display("FAIL clr_head got %0h want d0", rdata); end
        next_cycle();
        clr = 1'b1; wvalid = 1'b1; wdata = 32'hBAD; rready = 1'b1;
        #1;
        nvec++; if (depth !== 3'd4) begin nerr++; $display("FAIL clr_depth_before got %0d want 4", depth); end
        nvec++; if (a_req !== 1'b0 || b_req !== 1'b0) begin nerr++; $display("FAIL clr_req got %0h/%0h want 0/0", a_req, b_req); end
        next_cycle();
        clr = 1'b0; wvalid = 1'b0; rready = 1'b0;
        #1;
        nvec++; if (depth !== '0) begin nerr++; $display("FAIL clr_depth_after got %0d want 0", depth); end
        nvec++; if (rvalid !== 1'b0) begin nerr++; $display("FAIL clr_rvalid got %0h want 0", rvalid); end
        next_cycle();
        wvalid = 1'b1; wdata = 32'hC0DE; rready = 1'b1;
        next_cycle();
        wvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (rvalid === 1'b1) begin
                nvec++; if (rdata !== 32'hC0DE) begin nerr++; $display("FAIL clr_new_data got %0h want c0de", rdata); end
                n++;
            end
            next_cycle();
        end
        nvec++; if (n != 1) begin nerr++; $display("FAIL clr_new_count got %0d want 1", n); end
        rready = 1'b0;
        $display("test_clear done");
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [W-1:0] exp_d;
        int pops = 0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if (c < 5000) begin
                wvalid = $urandom_range(0, 1); rready = $urandom_range(0, 1);
            end else begin
                wvalid = ($urandom_range(0, 3) != 0); rready = ($urandom_range(0, 3) == 0);
                if (c >= 7500) begin wvalid = ($urandom_range(0, 3) == 0); rready = ($urandom_range(0, 3) != 0); end
            end
            wdata = $urandom;
            #1;
            nvec++; if (int'(depth) != q.size()) begin nerr++; $display("FAIL rand_depth got %0d want %0d", depth, q.size()); end
            if (a_req === 1'b1 && b_req === 1'b1) begin
                nvec++; if (a_addr === b_addr) begin nerr++; $display("FAIL rand_addr_clash got %0d want different from %0d", a_addr, b_addr); end
            end
            if (wvalid && wready) q.push_back(wdata);
            if (rvalid && rready) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 'x;
                nvec++; if (rdata !== exp_d) begin nerr++; $display("FAIL rand_data got %0h want %0h", rdata, exp_d); end
                pops++;
            end
            next_cycle();
        end
        wvalid = 1'b0; rready = 1'b0;
        $display("test_random done pops=%0d", pops);
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_addr_wrap();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
